// File: rtl/core_ram_loader.sv
// core_ram_loader
// Copies a word image from a valid/ready stream into a core-local RAM.
// The core is held in reset (core_hold=1) until its image is complete.
// An optional zero-fill of the whole RAM runs before the load.
// Optional readback verify: define CORE_RAM_LOADER_READBACK_EN to read back
// every written word and flag the first mismatching address.
// The RAM-side outputs are decoded combinationally from the state, so a
// stream word reaches the RAM in the same cycle it is accepted.
module core_ram_loader #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              clear_en,
  input  logic [ADDR_W:0]   length,
  input  logic              st_valid,
  input  logic [31:0]       st_data,
  output logic              st_ready,
  output logic [ADDR_W-1:0] ram_address,
  output logic [3:0]        ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [31:0]       ram_writedata,
  output logic              ram_clken,
  input  logic [31:0]       ram_readdata,
  output logic              busy,
  output logic              done,
  output logic              core_hold,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr
);

  localparam logic [ADDR_W:0] ZERO_C  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] LAST_C  = DEPTH_C - ONE_C;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLEAR    = 3'd1,
    LOAD     = 3'd2,
    DONE     = 3'd3
`ifdef CORE_RAM_LOADER_READBACK_EN
    ,
    RB_ADDR  = 3'd4,
    RB_CHECK = 3'd5
`endif
  } state_t;

  state_t          state_r, state_s;
  logic [ADDR_W:0] cnt_r, cnt_s;       // clear address, then word counter
  logic [ADDR_W:0] len_r, len_s;       // clamped word count for this load
  logic [ADDR_W:0] cnt_inc_s;
  logic [ADDR_W:0] len_clamp_s;

`ifdef CORE_RAM_LOADER_READBACK_EN
  logic [31:0]       wdata_r, wdata_s; // last word written, for readback compare
  logic              err_r, err_s;
  logic [ADDR_W-1:0] err_addr_r, err_addr_s;
`endif

  assign cnt_inc_s   = cnt_r + ONE_C;
  assign len_clamp_s = (length > DEPTH_C) ? DEPTH_C : length;
  assign ram_clken   = 1'b1;

  // Next-state logic and RAM/stream outputs; reset suppresses any transfer
  always_comb begin
    state_s        = state_r;
    cnt_s          = cnt_r;
    len_s          = len_r;
`ifdef CORE_RAM_LOADER_READBACK_EN
    wdata_s        = wdata_r;
    err_s          = err_r;
    err_addr_s     = err_addr_r;
`endif
    st_ready       = 1'b0;
    ram_address    = {ADDR_W{1'b0}};
    ram_byteenable = 4'h0;
    ram_chipselect = 1'b0;
    ram_write      = 1'b0;
    ram_writedata  = 32'h0;
    if (reset) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            len_s = len_clamp_s;
            cnt_s = ZERO_C;
`ifdef CORE_RAM_LOADER_READBACK_EN
            err_s      = 1'b0;
            err_addr_s = {ADDR_W{1'b0}};
`endif
            if (clear_en) begin
              state_s = CLEAR;
            end else if (len_clamp_s == ZERO_C) begin
              // nothing to load: finish without touching the stream
              state_s = DONE;
            end else begin
              state_s = LOAD;
            end
          end else begin
            state_s = state_r;
          end
        end
        CLEAR: begin
          ram_chipselect = 1'b1;
          ram_write      = 1'b1;
          ram_byteenable = 4'hF;
          ram_address    = cnt_r[ADDR_W-1:0];
          ram_writedata  = 32'h0;
          if (cnt_r == LAST_C) begin
            cnt_s   = ZERO_C;
            state_s = (len_r == ZERO_C) ? DONE : LOAD;
          end else begin
            cnt_s = cnt_inc_s;
          end
        end
        LOAD: begin
          st_ready    = 1'b1;
          ram_address = cnt_r[ADDR_W-1:0];
          if (st_valid) begin
            ram_chipselect = 1'b1;
            ram_write      = 1'b1;
            ram_byteenable = 4'hF;
            ram_writedata  = st_data;
`ifdef CORE_RAM_LOADER_READBACK_EN
            wdata_s = st_data;
            state_s = RB_ADDR;
`else
            cnt_s   = cnt_inc_s;
            state_s = (cnt_inc_s == len_r) ? DONE : LOAD;
`endif
          end else begin
            state_s = LOAD;
          end
        end
`ifdef CORE_RAM_LOADER_READBACK_EN
        RB_ADDR: begin
          // read back the word just written; data returns next cycle
          ram_chipselect = 1'b1;
          ram_write      = 1'b0;
          ram_byteenable = 4'hF;
          ram_address    = cnt_r[ADDR_W-1:0];
          state_s        = RB_CHECK;
        end
        RB_CHECK: begin
          if ((ram_readdata != wdata_r) && !err_r) begin
            err_s      = 1'b1;
            err_addr_s = cnt_r[ADDR_W-1:0];
          end else begin
            err_s = err_r;
          end
          cnt_s   = cnt_inc_s;
          state_s = (cnt_inc_s == len_r) ? DONE : LOAD;
        end
`endif
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= ZERO_C;
      len_r      <= ZERO_C;
`ifdef CORE_RAM_LOADER_READBACK_EN
      wdata_r    <= 32'h0;
      err_r      <= 1'b0;
      err_addr_r <= {ADDR_W{1'b0}};
`endif
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      len_r      <= len_s;
`ifdef CORE_RAM_LOADER_READBACK_EN
      wdata_r    <= wdata_s;
      err_r      <= err_s;
      err_addr_r <= err_addr_s;
`endif
    end
  end

  // Status decoded from the registered state
  always_comb begin
    done      = (state_r == DONE);
    core_hold = (state_r != DONE);
`ifdef CORE_RAM_LOADER_READBACK_EN
    busy      = (state_r == CLEAR) || (state_r == LOAD) ||
                (state_r == RB_ADDR) || (state_r == RB_CHECK);
`else
    busy      = (state_r == CLEAR) || (state_r == LOAD);
`endif
  end

`ifdef CORE_RAM_LOADER_READBACK_EN
  assign error    = err_r;
  assign err_addr = err_addr_r;
`else
  // read data only matters for readback; keep it visibly consumed
  logic unused_readdata_s;
  assign unused_readdata_s = ^ram_readdata;
  assign error    = 1'b0;
  assign err_addr = {ADDR_W{1'b0}};
`endif

endmodule

// File: tb/tb_core_ram_loader.sv
// tb_core_ram_loader: directed bench for core_ram_loader with a write
// scoreboard and a behavioural RAM. Works with or without
// CORE_RAM_LOADER_READBACK_EN (per-word cycle cost differs).
module tb_core_ram_loader;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
`ifdef CORE_RAM_LOADER_READBACK_EN
  localparam int WC = 3;   // cycles per loaded word
`else
  localparam int WC = 1;
`endif

  logic          clk, reset, start, clear_en, st_valid, st_ready;
  logic [AW:0]   length;
  logic [31:0]   st_data, ram_writedata, ram_readdata;
  logic [AW-1:0] ram_address, err_addr;
  logic [3:0]    ram_byteenable;
  logic          ram_chipselect, ram_write, ram_clken, busy, done, core_hold, error;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] mem [DEPTH];
  logic        corrupt;

  int   done_lat, n_hs, last_hs;
  logic hold_bad, ready_seen;

  core_ram_loader #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .clear_en(clear_en), .length(length),
    .st_valid(st_valid), .st_data(st_data), .st_ready(st_ready),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_clken(ram_clken), .ram_readdata(ram_readdata),
    .busy(busy), .done(done), .core_hold(core_hold), .error(error), .err_addr(err_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural RAM: registered read, word 7 reads back corrupted when enabled
  always @(posedge clk) begin
    if (ram_chipselect === 1'b1 && ram_write === 1'b1)
      mem[ram_address] <= ram_writedata;
    if (ram_chipselect === 1'b1 && ram_write === 1'b0)
      ram_readdata <= (corrupt && ram_address == 10'd7) ? (mem[ram_address] ^ 32'h1)
                                                       : mem[ram_address];
  end

  // Scoreboard: every RAM write must match the oldest expected write
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (ram_chipselect === 1'b1 && ram_write === 1'b1) begin
      check("write_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("wr_addr", 64'(ram_address), 64'(e.addr));
        check("wr_data", 64'(ram_writedata), 64'(e.data));
        check("wr_be", 64'(ram_byteenable), 64'hF);
      end
    end
  end

  // One load: pulse start, stream words, measure cycles (after the start edge) to done
  task automatic run_load(input logic ce, input logic [AW:0] len, input int nwords,
                          input logic [31:0] base, input int abort_at, input int budget);
    int   i;
    logic hs;
    exp_t e;
    i = 0; done_lat = -1; n_hs = 0; last_hs = 0;
    hold_bad = 1'b0; ready_seen = 1'b0;
    if (ce) begin
      for (int a = 0; a < DEPTH; a++) begin
        e.addr = a[AW-1:0];
        e.data = 32'h0;
        sb.push_back(e);
      end
    end
    @(posedge clk); #1;
    start = 1'b1; clear_en = ce; length = len;
    st_valid = (nwords > 0); st_data = base;
    @(posedge clk); #1;
    start = 1'b0; clear_en = 1'b0; length = '0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_lat = k;
        break;
      end
      if (core_hold !== 1'b1) hold_bad = 1'b1;
      if (st_ready === 1'b1) ready_seen = 1'b1;
      hs = (st_ready === 1'b1) && (st_valid === 1'b1);
      if (hs) begin
        e.addr = i[AW-1:0];
        e.data = st_data;
        sb.push_back(e);
        n_hs++;
        last_hs = k;
      end
      @(posedge clk); #1;
      if (hs) begin
        i++;
        st_data = base + 32'(i);
        if (i >= nwords) st_valid = 1'b0;
      end
      if (abort_at > 0 && i == abort_at) begin
        reset = 1'b1;
        break;
      end
    end
    if (abort_at == 0) st_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; clear_en = 1'b0; length = '0;
    st_valid = 1'b0; st_data = 32'h0; corrupt = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hold", 64'(core_hold), 64'd1);
    check("rst_error", 64'(error), 64'd0);
    check("rst_err_addr", 64'(err_addr), 64'd0);
    check("rst_ready", 64'(st_ready), 64'd0);
    check("rst_cs", 64'(ram_chipselect), 64'd0);
    check("rst_write", 64'(ram_write), 64'd0);
    check("rst_addr", 64'(ram_address), 64'd0);
    check("rst_wdata", 64'(ram_writedata), 64'd0);
    check("rst_be", 64'(ram_byteenable), 64'd0);
    check("rst_clken", 64'(ram_clken), 64'd1);

    // four words, no clear
    run_load(1'b0, 11'd4, 4, 32'hA0, 0, 100);
    check("a_last_write", 64'(last_hs), 64'(3 * WC + 1));
    check("a_done_lat", 64'(done_lat), 64'(4 * WC + 1));
    check("a_hold_low", 64'(core_hold), 64'd0);
    check("a_hold_busy", 64'(hold_bad), 64'd0);

    // clear then two words, restarted from DONE
    run_load(1'b1, 11'd2, 2, 32'hB000_0000, 0, 1200);
    check("b_done_lat", 64'(done_lat), 64'(1024 + 2 * WC + 1));
    check("b_hold_busy", 64'(hold_bad), 64'd0);

    // oversize length clamps to the RAM depth
    run_load(1'b0, 11'd2047, 1100, 32'h1000_0000, 0, 3200);
    check("c_words", 64'(n_hs), 64'd1024);
    check("c_done_lat", 64'(done_lat), 64'(1024 * WC + 1));

    // reset in the middle of a ten-word load
    run_load(1'b0, 11'd10, 10, 32'hC000_0000, 5, 100);
    check("e_words_before_rst", 64'(n_hs), 64'd5);
    @(negedge clk);
    check("e_rst_ready", 64'(st_ready), 64'd0);
    check("e_rst_write", 64'(ram_write), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0; st_valid = 1'b0;
    @(negedge clk);
    check("e_idle_busy", 64'(busy), 64'd0);
    check("e_idle_hold", 64'(core_hold), 64'd1);
    run_load(1'b0, 11'd3, 3, 32'hD000_0000, 0, 100);
    check("e_done_lat", 64'(done_lat), 64'(3 * WC + 1));
    check("e_hold_busy", 64'(hold_bad), 64'd0);

    // reset wins over start in the same cycle
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b1; clear_en = 1'b1; length = 11'd5;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0; clear_en = 1'b0; length = '0;
    @(negedge clk);
    check("p_busy", 64'(busy), 64'd0);
    check("p_done", 64'(done), 64'd0);
    check("p_write", 64'(ram_write), 64'd0);

    // zero-length load from IDLE
    run_load(1'b0, 11'd0, 0, 32'h0, 0, 20);
    check("d_done_lat", 64'(done_lat), 64'd1);
    check("d_ready_seen", 64'(ready_seen), 64'd0);

    // RAM corrupts word 7 on readback
    corrupt = 1'b1;
    run_load(1'b0, 11'd10, 10, 32'hE000_0000, 0, 200);
    check("f_done_lat", 64'(done_lat), 64'(10 * WC + 1));
`ifdef CORE_RAM_LOADER_READBACK_EN
    check("f_error", 64'(error), 64'd1);
    check("f_err_addr", 64'(err_addr), 64'd7);
`else
    check("f_error", 64'(error), 64'd0);
    check("f_err_addr", 64'(err_addr), 64'd0);
`endif

    repeat (2) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/core_ram_loader.md
CORE_RAM_LOADER -- requirements
Module: core_ram_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, the number of 32-bit words in the target core RAM.
REQ-002 The block SHALL have parameter ADDR_W, default 10, the RAM address width; DEPTH SHALL equal 2**ADDR_W.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: single-cycle load request.
REQ-006 The block SHALL have port clear_en, input, 1 bit: sampled with start; zero-fill the whole RAM before loading.
REQ-007 The block SHALL have port length, input, ADDR_W+1 bits: sampled with start; number of words to load.
REQ-008 The block SHALL have ports st_valid (input, 1), st_data (input, 32) and st_ready (output, 1): the image word stream.
REQ-009 The block SHALL have RAM-side outputs ram_address (ADDR_W), ram_byteenable (4), ram_chipselect (1), ram_write (1), ram_writedata (32) and ram_clken (1).
REQ-010 The block SHALL have port ram_readdata, input, 32 bits: the RAM read data, valid one cycle after its address.
REQ-011 The block SHALL have status outputs busy (1), done (1), core_hold (1), error (1) and err_addr (ADDR_W).

Function
REQ-012 The FSM SHALL have states IDLE, CLEAR, LOAD and DONE; RB_ADDR and RB_CHECK SHALL exist only under REQ-032.
REQ-013 In IDLE or DONE, start=1 SHALL latch clear_en and min(length, DEPTH), reset the word counter to 0, clear done, and go to CLEAR if clear_en=1, else to LOAD.
REQ-014 start SHALL be ignored while busy=1; busy SHALL be 1 exactly in CLEAR, LOAD, RB_ADDR and RB_CHECK.
REQ-015 In CLEAR the block SHALL write 32'h0 with byteenable 4'hF to addresses 0..DEPTH-1, one per cycle, in DEPTH consecutive cycles.
REQ-016 After the CLEAR write to DEPTH-1, the FSM SHALL go to LOAD.
REQ-017 On entry to LOAD with a latched length of 0, the FSM SHALL go directly to DONE with no stream handshake.
REQ-018 In LOAD, st_ready SHALL be 1; st_ready SHALL be 0 in every other state.
REQ-019 A word SHALL transfer on a cycle with st_valid=1 and st_ready=1; that cycle SHALL drive ram_chipselect=1, ram_write=1, ram_byteenable=4'hF, ram_address=counter and ram_writedata=st_data, combinationally.
REQ-020 The counter SHALL increment by 1 per transfer, with no wrap.
REQ-021 The transfer of word length-1 SHALL move the FSM to DONE on the next edge; throughput SHALL be 1 word per cycle.
REQ-022 ram_chipselect and ram_write SHALL be 0 in every cycle with no CLEAR write, transfer or readback read.
REQ-023 ram_clken SHALL be constant 1.
REQ-024 In DONE, done=1 and core_hold=0; core_hold SHALL be 1 in all other states, so the core is held until its image is complete.
REQ-025 start in DONE SHALL restart per REQ-013, reasserting core_hold on the next cycle.

Reset
REQ-026 reset=1 SHALL force the FSM to IDLE from any state, mid-CLEAR or mid-LOAD included, on the next edge; no partial transfer is completed.
REQ-027 After reset the outputs SHALL be: busy=0, done=0, core_hold=1, error=0, err_addr=0, st_ready=0, ram_chipselect=0, ram_write=0.
REQ-028 After reset, ram_address, ram_writedata and ram_byteenable SHALL be 0.
REQ-029 reset SHALL take priority over start in the same cycle.

Configuration
REQ-030 The block SHALL have a readback-verify feature controlled by macro CORE_RAM_LOADER_READBACK_EN.
REQ-031 Without the macro, the block SHALL behave as REQ-012..REQ-029 and error/err_addr SHALL be tied to 0.
REQ-032 With the macro, each LOAD transfer SHALL go LOAD -> RB_ADDR -> RB_CHECK -> LOAD; the final word SHALL go RB_CHECK -> DONE instead.
REQ-033 RB_ADDR SHALL drive a read of the same address: chipselect=1, write=0.
REQ-034 RB_CHECK SHALL compare ram_readdata with the registered written word.
REQ-035 On the first mismatch, error SHALL set (sticky until reset or accepted start) and err_addr SHALL capture the address; throughput becomes 1 word per 3 cycles.

Verification
REQ-036 Reset, then start with clear_en=0 and length=4, streaming continuous valid words A0..A3 -> writes to addresses 0..3 on 4 consecutive cycles; done=1 and core_hold=0 on the cycle after the last write.
REQ-037 start with clear_en=1 and length=2 -> 1024 zero writes to 0..1023, then 2 stream writes; done is asserted 1026+1 cycles after start.
REQ-038 length=2047 -> clamped to 1024 writes to 0..1023, then DONE; length=0 with clear_en=0 -> DONE one cycle after start, with st_ready never 1.
REQ-039 Assert reset at word 5 of 10, then restart with length=3 -> writes start again at address 0; core_hold stays 1 until the new DONE.
REQ-040 With the macro, a RAM model corrupting address 7 -> error=1, err_addr=7, load still completes, 3 cycles per word; without the macro, error stays 0.
